branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor and branch target buffer (BTB) for the 5-stage pipeline.
//  - Fetch side: looks up the fetch PC and supplies a predicted direction and target.
//  - Decode side: compares the resolved branch outcome against the prediction carried
//    in IF/ID. Produces branch_mispredicted, branch_taken and the corrected PC; these
//    feed the hazard/flush logic (IF flush on a taken mispredict).
//  - Trains the 2-bit saturating counters and BTB targets on resolved branches.
// PARAMETERS
//  PC_W        16  PC / target width in bits (byte-addressed, instructions 2 bytes)
//  INDEX_BITS  3   table index width; 2**INDEX_BITS entries indexed by PC[INDEX_BITS:1]
// PORTS
//  clk                    in   1     system clock, all state updates on posedge
//  rst_n                  in   1     synchronous active-low reset
//  PC_stall               in   1     fetch stalled; prediction outputs are still driven
//  IF_PC_curr             in   PC_W  PC being fetched this cycle
//  predicted_taken        out  1     fetch-side prediction: taken
//  predicted_target       out  PC_W  fetch-side predicted target (0 when no BTB hit)
//  IF_ID_stall            in   1     branch held in ID by hazard; blocks resolve/update
//  IF_ID_PC_curr          in   PC_W  PC of the instruction in ID
//  IF_ID_predicted_taken  in   1     prediction carried with the ID instruction
//  IF_ID_predicted_target in   PC_W  predicted target carried with the ID instruction
//  is_branch              in   1     ID instruction is B or BR
//  actual_taken           in   1     resolved condition in ID (valid with is_branch)
//  actual_target          in   PC_W  resolved target in ID (B: PC+2+offset, BR: Rs)
//  branch_taken           out  1     is_branch & actual_taken & ~IF_ID_stall
//  branch_mispredicted    out  1     resolved outcome differs from prediction
//  correct_PC             out  PC_W  PC to refetch on mispredict
// BEHAVIOUR
//  State per entry i: valid[i], tag[i] (PC[PC_W-1:INDEX_BITS+1]), target[i] (PC_W),
//  ctr[i] (2 bits: 00 SNT, 01 WNT, 10 WT, 11 ST).
//  Reset (rst_n=0 at posedge): valid=0, tag=0, target=0, ctr=01 for every entry.
//  Reset takes priority over a same-cycle update. Outputs after reset:
//  predicted_taken=0, predicted_target=0. branch_* and correct_PC are combinational
//  from ID inputs and are not affected by reset.
//  Lookup (combinational, 0-cycle latency from IF_PC_curr):
//  - hit = valid[idx] & (tag[idx] == IF_PC_curr tag bits).
//  - predicted_taken = hit & ctr[idx][1].
//  - predicted_target = hit ? target[idx] : 0.
//  - Tables read asynchronously; registered state only.
//  Resolve (combinational, valid when resolve = is_branch & ~IF_ID_stall):
//  - branch_mispredicted = resolve & ((actual_taken != IF_ID_predicted_taken) |
//    (actual_taken & (actual_target != IF_ID_predicted_target))).
//  - correct_PC = actual_taken ? actual_target : IF_ID_PC_curr + 2 (mod 2**PC_W wrap).
//  - ~resolve forces branch_mispredicted=0 and branch_taken=0.
//  Update (posedge, when resolve), index/tag from IF_ID_PC_curr:
//  - Counter: actual_taken -> ctr=sat_inc (11 stays 11); else ctr=sat_dec (00 stays 00).
//  - Counter is updated even on a tag miss; the counter is untagged.
//  - actual_taken: valid=1, tag and target overwritten with current values.
//  - Not-taken: valid, tag and target unchanged.
//  - Exactly one update per branch. A branch held in ID by IF_ID_stall does not update
//    until the cycle it leaves ID.
//  Simultaneous lookup and update of the same index: lookup sees the pre-update value;
//  the new value is visible from the next cycle.
//  PC_stall has no effect on table state.
//  Aliasing: differing tags on the same index overwrite the entry (no associativity).
// TESTING
//  1. Reset, then IF_PC_curr=0x0010 -> predicted_taken=0, predicted_target=0x0000.
//  2. Branch at 0x0010, taken to 0x0040, predicted NT, no stall -> branch_mispredicted=1,
//     branch_taken=1, correct_PC=0x0040. Next cycle lookup of 0x0010 -> hit, ctr=10,
//     predicted_taken=1, target 0x0040.
//  3. Same branch resolved not-taken with prediction T/0x0040 -> mispredicted=1,
//     correct_PC=0x0012, ctr 10->01, next lookup predicted_taken=0, target still 0x0040.
//  4. Taken branch held with IF_ID_stall=1 for 3 cycles, then released -> outputs 0
//     while stalled; ctr increments exactly once on release.
//  5. Four consecutive taken resolves on 0x0010 -> ctr saturates at 11. Then one
//     not-taken -> 10, still predicts taken.
//  6. Alias: 0x0010 taken, then 0x0020 (same idx, INDEX_BITS=3) taken to 0x0080 ->
//     lookup 0x0010 misses. Also check same-cycle lookup/update returns the old value,
//     and rst_n low mid-training clears all entries.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and decode-side resolve signals between the pipeline and the branch predictor.
// The master modport belongs to the pipeline, the slave modport to the predictor.
interface branch_predictor_if #(
   parameter int PC_W = 16
);
   logic            PC_stall;
   logic [PC_W-1:0] IF_PC_curr;
   logic            predicted_taken;
   logic [PC_W-1:0] predicted_target;
   logic            IF_ID_stall;
   logic [PC_W-1:0] IF_ID_PC_curr;
   logic            IF_ID_predicted_taken;
   logic [PC_W-1:0] IF_ID_predicted_target;
   logic            is_branch;
   logic            actual_taken;
   logic [PC_W-1:0] actual_target;
   logic            branch_taken;
   logic            branch_mispredicted;
   logic [PC_W-1:0] correct_PC;

   modport master (
      output PC_stall, IF_PC_curr, IF_ID_stall, IF_ID_PC_curr,
             IF_ID_predicted_taken, IF_ID_predicted_target,
             is_branch, actual_taken, actual_target,
      input  predicted_taken, predicted_target,
             branch_taken, branch_mispredicted, correct_PC
   );

   modport slave (
      input  PC_stall, IF_PC_curr, IF_ID_stall, IF_ID_PC_curr,
             IF_ID_predicted_taken, IF_ID_predicted_target,
             is_branch, actual_taken, actual_target,
      output predicted_taken, predicted_target,
             branch_taken, branch_mispredicted, correct_PC
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with untagged 2-bit counters; predicts at fetch, resolves and trains from ID.
// Latency: lookup and resolve are combinational; table writes become visible the cycle after.
// Backpressure: IF_ID_stall holds off resolve and update; PC_stall never touches table state.
module branch_predictor #(
   parameter int PC_W       = 16,
   parameter int INDEX_BITS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   branch_predictor_if.slave bp
);
   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = PC_W - INDEX_BITS - 1;

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
   } btb_ent_t;

   btb_ent_t              btb [ENTRIES];
   logic [1:0]            ctr [ENTRIES];

   logic [INDEX_BITS-1:0] if_idx;
   logic [INDEX_BITS-1:0] id_idx;
   logic [TAG_W-1:0]      if_tag;
   logic [TAG_W-1:0]      id_tag;
   btb_ent_t              if_ent;
   logic                  hit;
   logic                  resolve;
   logic                  unused_bits;

   // Instructions are 2-byte aligned, so PC[0] never selects an entry.
   assign if_idx = bp.IF_PC_curr[INDEX_BITS:1];
   assign if_tag = bp.IF_PC_curr[PC_W-1:INDEX_BITS+1];
   assign id_idx = bp.IF_ID_PC_curr[INDEX_BITS:1];
   assign id_tag = bp.IF_ID_PC_curr[PC_W-1:INDEX_BITS+1];

   assign unused_bits = ^{bp.PC_stall, bp.IF_PC_curr[0]};

   always_comb begin
      if_ent              = btb[if_idx];
      hit                 = if_ent.vld && (if_ent.tag == if_tag);
      bp.predicted_taken  = hit && ctr[if_idx][1];
      bp.predicted_target = hit ? if_ent.target : '0;
   end

   assign resolve                = bp.is_branch && !bp.IF_ID_stall;
   assign bp.branch_taken        = resolve && bp.actual_taken;
   assign bp.branch_mispredicted = resolve &&
                                   ((bp.actual_taken != bp.IF_ID_predicted_taken) ||
                                    (bp.actual_taken &&
                                     (bp.actual_target != bp.IF_ID_predicted_target)));
   assign bp.correct_PC          = bp.actual_taken ? bp.actual_target
                                                   : bp.IF_ID_PC_curr + PC_W'(2);

   // Counters train even on a tag miss; only taken branches claim the BTB entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb[i] <= '0;
            ctr[i] <= 2'b01;
         end
      end else if (resolve) begin
         if (bp.actual_taken) begin
            if (ctr[id_idx] != 2'b11) ctr[id_idx] <= ctr[id_idx] + 2'b01;
            btb[id_idx] <= btb_ent_t'{vld: 1'b1, tag: id_tag, target: bp.actual_target};
         end else begin
            if (ctr[id_idx] != 2'b00) ctr[id_idx] <= ctr[id_idx] - 2'b01;
         end
      end
   end
endmodule
